closest_hit_reducer: RTL

- Sits directly downstream of the pipelined triangle intersection stage.
- Consumes one intersection result per cycle (t, hit flag, valid) for one ray tested against a stream of i_num_tris triangles, issued in index order.
- Keeps the nearest accepted hit and its triangle index, then presents one registered hit record to the shader/output stage with a valid/ready handshake.
- All t values are signed 16.16 fixed point (one = 32'sh00010000).

---
 rtl/closest_hit_reducer.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/closest_hit_reducer.sv
// Closest-hit reducer: keeps the nearest accepted intersection of one ray and emits one hit record.
// Optional shadow/any-hit mode is enabled by defining CLOSEST_HIT_ANY_EN.
module closest_hit_reducer #(
  parameter int unsigned        IDX_W  = 16,
  parameter logic signed [31:0] T_INIT = 32'sh7fffffff
) (
  input  logic                    i_clk,
  input  logic                    i_rstn,
  input  logic                    i_start,
  input  logic [IDX_W-1:0]        i_num_tris,
  input  logic signed [31:0]      i_t_max,
`ifdef CLOSEST_HIT_ANY_EN
  input  logic                    i_any_hit,
`endif
  input  logic                    i_valid,
  input  logic                    i_result,
  input  logic signed [31:0]      i_t,
  output logic                    o_busy,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic                    o_hit,
  output logic signed [31:0]      o_t,
  output logic [IDX_W-1:0]        o_tri_idx,
  output logic                    o_err
);

  typedef enum logic [1:0] {StIdle, StAccum, StDone} state_e;

  state_e             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_num_tris, r_cnt, r_best_idx, r_idx;
  logic signed [31:0] r_t_max, r_best_t, r_t;
  logic               r_best_hit, r_hit, r_valid, r_err, r_acked, r_settle;

  logic               w_take, w_last, w_accept, w_acked, w_drain_pend, w_drain;
  logic               w_any_stop, w_load, w_orphan;
  logic [IDX_W-1:0]   w_cnt_nxt;

`ifdef CLOSEST_HIT_ANY_EN
  logic r_any_hit;
  assign w_any_stop   = r_any_hit && w_take;
  assign w_drain_pend = (r_cnt != r_num_tris);
`else
  assign w_any_stop   = 1'b0;
  assign w_drain_pend = 1'b0;
`endif

  // Strict less-than keeps the earlier index on a tie.
  assign w_take   = (r_state == StAccum) && i_valid && i_result &&
                    (i_t <= r_t_max) && (i_t < r_best_t);
  assign w_last   = (r_cnt == r_num_tris - IDX_W'(1));
  assign w_accept = r_valid && i_ready;
  assign w_acked  = r_acked || w_accept;
  assign w_drain  = (r_state == StDone) && i_valid && w_drain_pend;
  assign w_orphan = i_valid && ((r_state == StIdle) ||
                                ((r_state == StDone) && !w_drain_pend));
  // The record is loaded on the second DONE cycle, giving a two-cycle result latency.
  assign w_load   = (r_state == StDone) && r_settle && !r_valid && !r_acked;

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (((r_state == StAccum) && i_valid) || w_drain) begin
      w_cnt_nxt = r_cnt + IDX_W'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_state_nxt = (i_num_tris == '0) ? StDone : StAccum;
        end
      end
      StAccum: begin
        if (i_valid && (w_last || w_any_stop)) begin
          w_state_nxt = StDone;
        end
      end
      StDone: begin
        if (w_acked && (w_cnt_nxt == r_num_tris)) begin
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      r_num_tris <= '0;
      r_t_max    <= '0;
      r_cnt      <= '0;
      r_best_t   <= T_INIT;
      r_best_hit <= 1'b0;
      r_best_idx <= '0;
      r_hit      <= 1'b0;
      r_t        <= T_INIT;
      r_idx      <= '0;
      r_valid    <= 1'b0;
      r_err      <= 1'b0;
      r_acked    <= 1'b0;
      r_settle   <= 1'b0;
`ifdef CLOSEST_HIT_ANY_EN
      r_any_hit  <= 1'b0;
`endif
    end else begin
      if ((r_state == StIdle) && i_start) begin
        r_num_tris <= i_num_tris;
        r_t_max    <= i_t_max;
        r_cnt      <= '0;
        r_best_t   <= T_INIT;
        r_best_hit <= 1'b0;
        r_best_idx <= '0;
        r_acked    <= 1'b0;
`ifdef CLOSEST_HIT_ANY_EN
        r_any_hit  <= i_any_hit;
`endif
      end else begin
        r_cnt <= w_cnt_nxt;
      end

      if (w_take) begin
        r_best_t   <= i_t;
        r_best_hit <= 1'b1;
        r_best_idx <= r_cnt;
      end

      r_settle <= (r_state == StDone);

      if (w_load) begin
        r_valid <= 1'b1;
        r_hit   <= r_best_hit;
        r_t     <= r_best_t;
        r_idx   <= r_best_idx;
      end else if (w_accept) begin
        r_valid <= 1'b0;
      end

      if (w_accept) begin
        r_acked <= 1'b1;
      end

      if (w_orphan) begin
        r_err <= 1'b1;
      end
    end
  end

  assign o_busy    = (r_state != StIdle);
  assign o_valid   = r_valid;
  assign o_hit     = r_hit;
  assign o_t       = r_t;
  assign o_tri_idx = r_idx;
  assign o_err     = r_err;

endmodule
